alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's combinational ALU.
- Keeps the existing opcode map 0000–1000 and adds multiply, unsigned divide and shifts.
- Adds a start/busy/done handshake and a full flag set (Z, C, N, V, DZ).
- Sits between the register-file read ports and the write-back mux; the decode/control FSM stalls on busy.

Parameters:
- WIDTH, 10, data width of A, B and result.
- IMM_W, 4, width of the immediate operand (zero-extended to WIDTH).
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch the operation; sampled only in IDLE.
- ALU_cntrl  input  4  opcode from decode; sampled with start.
- A  input  WIDTH  RF operand A; sampled with start.
- B  input  WIDTH  RF operand B; sampled with start.
- imm_num  input  IMM_W  immediate; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags valid.
- D_output  output  WIDTH  result (low word for MUL, quotient for DIV).
- D_hi  output  WIDTH  MUL high word / DIV remainder; 0 for other ops.
- Z  output  1  D_output == 0.
- C  output  1  carry-out (ADD/INC), borrow (SUB/DEC, LT compare), last bit shifted out (SHL/SHR); 0 otherwise.
- N  output  1  D_output[WIDTH-1].
- V  output  1  two's-complement overflow for ADD/SUB/INC/DEC; 0 otherwise.
- DZ  output  1  divide by zero (DIV with B == 0).

Behaviour:
- Reset (async, rst_n low): state = IDLE; busy, done, D_output, D_hi, Z, C, N, V, DZ all 0; iteration counter 0. Reset mid-operation aborts immediately with no done.
- FSM states IDLE, RUN, DONE. All outputs are registered.
- IDLE with start = 1: latch opcode and operands. Single-cycle ops go to DONE. MUL/DIV go to RUN, busy = 1, counter = 0.
- RUN: one shift-add (MUL) or one restoring-subtract (DIV) step per cycle. After WIDTH steps, go to DONE.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE. Results and flags are updated on entry to DONE and held until the next entry to DONE.
- Latency, start sampled at edge 0:
  - single-cycle ops: done high in the cycle after edge 1;
  - MUL/DIV: busy high from edge 0 to edge WIDTH, done high in the cycle after edge WIDTH+1.
- start while busy or in DONE is ignored; no queueing. start in the same cycle that done is high is also ignored; the next op must be re-issued in IDLE.
- Opcodes; immediate = zero-extended imm_num; arithmetic mod 2^WIDTH:
  - 0000 NOT: ~A.
  - 0001 LT: result 0 if A < B (unsigned), else 1. This inverted sense is retained for ISA compatibility.
  - 0010 INC: A + imm.
  - 0011 DEC: A − imm.
  - 0100 ADD: A + B.
  - 0101 SUB: A − B.
  - 0110 AND: A & B.
  - 0111 OR: A | B.
  - 1000 PASS: A.
  - 1001 MUL: unsigned; {D_hi, D_output} = A × B (2·WIDTH bits).
  - 1010 DIV: unsigned; D_output = A / B, D_hi = A % B.
  - 1011 SHL: A << imm; C = last bit out; shift ≥ WIDTH gives 0.
  - 1100 SHR: logical A >> imm; same rules as SHL.
  - 1101–1111: PASS A, all flags except Z and N cleared.
- DIV with B = 0: still takes the full iterative latency; D_output = all ones, D_hi = A, DZ = 1. DZ = 0 for every other case.
- Z and N are always derived from D_output only, never D_hi.

Test Plan:
- Reset mid-MUL: start MUL A=25, B=30; drop rst_n at cycle 4 → all outputs 0 immediately, no done pulse, next op runs normally.
- ADD A=1023, B=1, then INC A=1022, imm=1 → D_output=0, Z=1, C=1, V=0; then D_output=1023, Z=0, C=0, N=1; done one cycle after start each time.
- SUB A=5, B=7 → D_output=1022, C=1, N=1, Z=0. Then SUB A=512, B=1 → D_output=511, V=1.
- MUL A=1023, B=1023 → busy for 11 cycles, D_hi=1022, D_output=1, single done pulse. MUL A=25, B=30 → D_output=750, D_hi=0.
- DIV A=1000, B=7 → D_output=142, D_hi=6, DZ=0. DIV A=300, B=0 → D_output=1023, D_hi=300, DZ=1.
- Pulse start every cycle during a MUL → only the first op executes, exactly one done. LT A=3, B=9 → D_output=0, Z=1. SHL A=0x201, imm=1 → D_output=0x002, C=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake: single-cycle logic/arith ops,
// WIDTH-step shift-add multiply and restoring divide, full Z/C/N/V/DZ flag set.
module alu_seq #(
    parameter int WIDTH = 10,
    parameter int IMM_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_cntrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [IMM_W-1:0] imm_num,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D_output,
    output logic [WIDTH-1:0] D_hi,
    output logic             Z,
    output logic             C,
    output logic             N,
    output logic             V,
    output logic             DZ
);

    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [3:0] {
        OP_NOT = 4'b0000, OP_LT  = 4'b0001, OP_INC = 4'b0010, OP_DEC = 4'b0011,
        OP_ADD = 4'b0100, OP_SUB = 4'b0101, OP_AND = 4'b0110, OP_OR  = 4'b0111,
        OP_PAS = 4'b1000, OP_MUL = 4'b1001, OP_DIV = 4'b1010, OP_SHL = 4'b1011,
        OP_SHR = 4'b1100
    } op_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d, dhi_q, dhi_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d, dz_q, dz_d;

    logic [WIDTH-1:0] imm_ext, res_s, hi_s, div_sh;
    logic [WIDTH:0]   sum, tmp_l, tmp_r, mul_sum;
    logic             c_s, v_s, dz_s, div_ge;

    assign imm_ext = {{(WIDTH-IMM_W){1'b0}}, imm_q};

    always_comb begin : alu
        sum   = '0;
        tmp_l = {1'b0, a_q} << imm_q;
        tmp_r = {a_q, 1'b0} >> imm_q;
        res_s = a_q;
        hi_s  = '0;
        c_s   = 1'b0;
        v_s   = 1'b0;
        dz_s  = 1'b0;
        case (op_q)
            OP_NOT: res_s = ~a_q;
            OP_LT: begin
                c_s   = a_q < b_q;
                res_s = (a_q < b_q) ? '0 : WIDTH'(1);
            end
            OP_INC: begin
                sum   = {1'b0, a_q} + {1'b0, imm_ext};
                res_s = sum[M:0];
                c_s   = sum[WIDTH];
                v_s   = (a_q[M] == imm_ext[M]) && (sum[M] != a_q[M]);
            end
            OP_DEC: begin
                sum   = {1'b0, a_q} - {1'b0, imm_ext};
                res_s = sum[M:0];
                c_s   = sum[WIDTH];
                v_s   = (a_q[M] != imm_ext[M]) && (sum[M] != a_q[M]);
            end
            OP_ADD: begin
                sum   = {1'b0, a_q} + {1'b0, b_q};
                res_s = sum[M:0];
                c_s   = sum[WIDTH];
                v_s   = (a_q[M] == b_q[M]) && (sum[M] != a_q[M]);
            end
            OP_SUB: begin
                sum   = {1'b0, a_q} - {1'b0, b_q};
                res_s = sum[M:0];
                c_s   = sum[WIDTH];
                v_s   = (a_q[M] != b_q[M]) && (sum[M] != a_q[M]);
            end
            OP_AND: res_s = a_q & b_q;
            OP_OR:  res_s = a_q | b_q;
            OP_MUL: begin
                res_s = lo_q;
                hi_s  = hi_q;
            end
            OP_DIV: begin
                res_s = lo_q;
                hi_s  = hi_q;
                dz_s  = (b_q == '0);
            end
            // One guard bit beyond the word catches the last bit shifted out.
            OP_SHL: begin
                res_s = tmp_l[M:0];
                c_s   = tmp_l[WIDTH];
            end
            OP_SHR: begin
                res_s = tmp_r[WIDTH:1];
                c_s   = tmp_r[0];
            end
            default: res_s = a_q;
        endcase
    end

    // Divisor 0 always compares as "fits", yielding all-ones quotient and remainder A.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign div_sh  = {hi_q[M-1:0], lo_q[M]};
    assign div_ge  = {hi_q, lo_q[M]} >= {1'b0, b_q};

    always_comb begin : fsm
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dhi_d   = dhi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
        c_d     = c_q;
        n_d     = n_q;
        v_d     = v_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    op_d   = ALU_cntrl;
                    a_d    = A;
                    b_d    = B;
                    imm_d  = imm_num;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    hi_d   = '0;
                    lo_d   = (ALU_cntrl == OP_DIV) ? A : B;
                    if (ALU_cntrl == OP_MUL || ALU_cntrl == OP_DIV) state_d = RUN;
                    else                                              state_d = DONE;
                end
            end
            RUN: begin
                if (op_q == OP_MUL) begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[M:1]};
                end else begin
                    hi_d = div_ge ? (div_sh - b_q) : div_sh;
                    lo_d = {lo_q[M-1:0], div_ge};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                dout_d  = res_s;
                dhi_d   = hi_s;
                z_d     = (res_s == '0);
                n_d     = res_s[M];
                c_d     = c_s;
                v_d     = v_s;
                dz_d    = dz_s;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dhi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dhi_q   <= dhi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            c_q     <= c_d;
            n_q     <= n_d;
            v_q     <= v_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign D_output = dout_q;
    assign D_hi     = dhi_q;
    assign Z        = z_q;
    assign C        = c_q;
    assign N        = n_q;
    assign V        = v_q;
    assign DZ       = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=10) with hand-computed expectations.
module tb_alu_seq;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   ALU_cntrl;
    logic [W-1:0] A, B;
    logic [3:0]   imm_num;
    logic         busy, done, Z, C, N, V, DZ;
    logic [W-1:0] D_output, D_hi;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W), .IMM_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALU_cntrl(ALU_cntrl),
        .A(A), .B(B), .imm_num(imm_num), .busy(busy), .done(done),
        .D_output(D_output), .D_hi(D_hi), .Z(Z), .C(C), .N(N), .V(V), .DZ(DZ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flags are compared packed as {Z,C,N,V,DZ}.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [3:0] imm, input int exp_lat,
                          input logic [W-1:0] exp_d, input logic [W-1:0] exp_hi,
                          input logic [4:0] exp_f);
        int lat = 0;
        int nbusy = 0;
        ALU_cntrl = op; A = a; B = b; imm_num = imm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = 10'h155; B = 10'h0AA; imm_num = 4'h7;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cyc"}, 32'(nbusy), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_d"}, 32'(D_output), 32'(exp_d));
        check({tag, "_hi"}, 32'(D_hi), 32'(exp_hi));
        check({tag, "_flags"}, 32'({Z, C, N, V, DZ}), 32'(exp_f));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; ALU_cntrl = '0; A = '0; B = '0; imm_num = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", 32'({busy, done, Z, C, N, V, DZ}), 32'd0);
        check("rst_d", 32'(D_output), 32'd0);
        check("rst_hi", 32'(D_hi), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add",  4'b0100, 10'd1023, 10'd1,    4'd0,  1, 10'd0,    10'd0, 5'b11000);
        run_op("inc",  4'b0010, 10'd1022, 10'd0,    4'd1,  1, 10'd1023, 10'd0, 5'b00100);
        run_op("sub1", 4'b0101, 10'd5,    10'd7,    4'd0,  1, 10'd1022, 10'd0, 5'b01100);
        run_op("sub2", 4'b0101, 10'd512,  10'd1,    4'd0,  1, 10'd511,  10'd0, 5'b00010);
        run_op("dec",  4'b0011, 10'd0,    10'd0,    4'd1,  1, 10'd1023, 10'd0, 5'b01100);
        run_op("mul1", 4'b1001, 10'd1023, 10'd1023, 4'd0, 11, 10'd1,    10'd1022, 5'b00000);
        run_op("mul2", 4'b1001, 10'd25,   10'd30,   4'd0, 11, 10'd750,  10'd0, 5'b00100);
        run_op("div1", 4'b1010, 10'd1000, 10'd7,    4'd0, 11, 10'd142,  10'd6, 5'b00000);
        run_op("div0", 4'b1010, 10'd300,  10'd0,    4'd0, 11, 10'd1023, 10'd300, 5'b00101);
        run_op("lt",   4'b0001, 10'd3,    10'd9,    4'd0,  1, 10'd0,    10'd0, 5'b11000);
        run_op("ltge", 4'b0001, 10'd9,    10'd9,    4'd0,  1, 10'd1,    10'd0, 5'b00000);
        run_op("shl",  4'b1011, 10'h201,  10'd0,    4'd1,  1, 10'h002,  10'd0, 5'b01000);
        run_op("shlw", 4'b1011, 10'h3FF,  10'd0,    4'd10, 1, 10'd0,    10'd0, 5'b11000);
        run_op("shlb", 4'b1011, 10'h3FF,  10'd0,    4'd12, 1, 10'd0,    10'd0, 5'b10000);
        run_op("shr",  4'b1100, 10'h201,  10'd0,    4'd1,  1, 10'h100,  10'd0, 5'b01000);
        run_op("not",  4'b0000, 10'd0,    10'd0,    4'd0,  1, 10'd1023, 10'd0, 5'b00100);
        run_op("and",  4'b0110, 10'h3C3,  10'h0FF,  4'd0,  1, 10'h0C3,  10'd0, 5'b00000);
        run_op("or",   4'b0111, 10'h300,  10'h00F,  4'd0,  1, 10'h30F,  10'd0, 5'b00100);
        run_op("rsv",  4'b1111, 10'h3FF,  10'd5,    4'd15, 1, 10'h3FF,  10'd0, 5'b00100);

        // start held high throughout a MUL and through its done cycle.
        ndone = 0;
        ALU_cntrl = 4'b1001; A = 10'd3; B = 10'd4; start = 1'b1;
        @(posedge clk); #1;
        ALU_cntrl = 4'b0100; A = 10'd100; B = 10'd200;
        for (int i = 0; i < 40 && ndone == 0; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check("hold_ndone", 32'(ndone), 32'd1);
        check("hold_d", 32'(D_output), 32'd12);
        check("hold_busy", 32'(busy), 32'd0);

        // Reset in the middle of a MUL, after a result with nonzero outputs.
        ALU_cntrl = 4'b1001; A = 10'd25; B = 10'd30; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mrst_ctl", 32'({busy, done, Z, C, N, V, DZ}), 32'd0);
        check("mrst_d", 32'(D_output), 32'd0);
        check("mrst_hi", 32'(D_hi), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("mrst_quiet", 32'(ndone), 32'd0);
        run_op("post", 4'b0100, 10'd100, 10'd200, 4'd0, 1, 10'd300, 10'd0, 5'b00000);
        run_op("postm", 4'b1001, 10'd25, 10'd30, 4'd0, 11, 10'd750, 10'd0, 5'b00100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
